sdram_responder: RTL and testbench
==================================

// Module: sdram_responder
// PURPOSE
//  Synthesizable SDRAM device model: the chip side of the SDRAM command bus driven by the
//  system's SDRAM controller. Decodes ACTIVE/READ/WRITE/PRECHARGE/REFRESH/LOAD_MODE,
//  tracks per-bank open rows, and serves data from an internal RAM with mode-register CAS
//  latency. Sits in sim/FPGA test tops in place of the external chip; flags protocol errors.
// PARAMETERS
//  DATA_WIDTH  16  dq width, 16 or 32; DQM width = DATA_WIDTH/8
//  RAS_WIDTH   13  row address bits on sd_addr
//  CAS_WIDTH    9  column address bits
//  MEM_AW      16  backing-store word address bits (2^MEM_AW words of DATA_WIDTH)
//  T_RCD        1  min clocks ACTIVE->READ/WRITE, same bank (timing check only)
//  T_RP         1  min clocks PRECHARGE->ACTIVE, same bank (timing check only)
// PORTS
//  clk          in   1             sdram clock; all commands sampled on rising edge
//  reset        in   1             synchronous, active-high
//  sd_cs        in   1             chip select, active low; high = NOP
//  sd_ras/cas/we in  1 each        command {ras,cas,we}, active low
//  sd_ba        in   2             bank
//  sd_addr      in   RAS_WIDTH     multiplexed address; A10 = auto/all-precharge
//  sd_dqm       in   DATA_WIDTH/8  byte masks, 1 = masked
//  sd_dq_i      in   DATA_WIDTH    bus from controller (write data)
//  sd_dq_o      out  DATA_WIDTH    read data
//  sd_dq_oe     out  1             responder drives bus
//  mode_valid   out  1             LOAD_MODE accepted since reset
//  cas_lat      out  2             active CAS latency (2 or 3)
//  bank_open    out  4             per-bank row-open flags
//  refresh_cnt  out  16            AUTO_REFRESH count, saturating
//  err          out  1             sticky protocol error
//  err_code     out  3             code of first error
// BEHAVIOUR
//  Reset: banks closed, mode_valid=0, cas_lat=2, sd_dq_oe=0, sd_dq_o=0, refresh_cnt=0,
//   err=0, err_code=0, read pipeline flushed (reset mid-read: no data driven). RAM not reset.
//  Erroneous command: sets err/err_code (first only), otherwise ignored (no state change).
//  LOAD_MODE 000: all banks idle else code 1; CL=addr[6:4] in {2,3} and BL=addr[2:0]=000
//   else code 2; accepted -> cas_lat=CL, mode_valid=1.
//  ACTIVE 011: mode_valid else code 2; bank closed else code 3; store row=sd_addr.
//  READ 101 / WRITE 100: mode_valid else 2; bank open else 4; col=sd_addr[CAS_WIDTH-1:0];
//   index = {ba,row,col} truncated to MEM_AW LSBs; A10=1 closes bank on the command edge.
//  WRITE: sd_dq_i sampled on command edge; bytes with dqm=0 written, dqm=1 lanes preserved.
//  READ at edge t: sd_dq_o registered at edge t+CL-1, sd_dq_oe high exactly one cycle, so
//   controller samples at edge t+CL. dqm sampled at t; masked lanes driven 0.
//   3-deep read pipeline: back-to-back READs return in order, one per cycle.
//   WRITE data read at t returns written value only if WRITE edge < t.
//  PRECHARGE 010: A10=1 closes all banks, else bank sd_ba; idle bank is legal (no-op).
//  AUTO_REFRESH 001: all banks idle else code 6; refresh_cnt+1, saturates at 0xFFFF.
//  BURST_TERMINATE 110: code 7. NOP 111 or sd_cs=1: nothing.
//  Codes: 1 mode w/ open bank, 2 bad mode/not ready, 3 double ACTIVE, 4 access closed
//   bank, 5 timing, 6 refresh w/ open bank, 7 burst terminate.
// CONFIGURATION
//  SDRAM_RESP_TIMING_EN defined: per-bank cycle counters (saturating at 7); READ/WRITE
//   < T_RCD clocks after ACTIVE, or ACTIVE < T_RP clocks after PRECHARGE/auto-precharge
//   -> code 5. Undefined: no counters, code 5 never raised.
// TESTING
//  1 reset; PRECHARGE A10=1; LOAD_MODE addr=0x220 -> mode_valid=1, cas_lat=2, err=0.
//  2 ACTIVE b0 row5; WRITE col3 A10=1 dq=0xBEEF dqm=00; ACTIVE; READ col3 @t ->
//    sd_dq_oe=1 only in cycle after edge t+1, dq=0xBEEF; bank_open[0]=0 after.
//  3 WRITE 0x1234 dqm=01 over 0xBEEF -> read 0x12EF; LOAD_MODE 0x230 -> data 1 clk later.
//  4 READ idle bank -> err=1,code 4; later ACTIVE twice same bank -> code stays 4.
//  5 T_RCD=2, READ 1 clk after ACTIVE -> code 5 with SDRAM_RESP_TIMING_EN, err=0 without.
//  6 READ then reset next edge -> sd_dq_oe stays 0; REFRESH w/ open bank -> code 6.

Source files
------------

// File: rtl/sdram_responder.sv
// sdram_responder: chip-side SDRAM device model for simulation and FPGA test tops.
// Decodes the SDRAM command bus, tracks per-bank open rows, serves reads from an
// internal RAM at the programmed CAS latency, and flags protocol errors.
// Optional build macro: SDRAM_RESP_TIMING_EN adds per-bank tRCD/tRP checking (code 5).
module sdram_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RAS_WIDTH  = 13,
  parameter int unsigned CAS_WIDTH  = 9,
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned T_RCD      = 1,
  parameter int unsigned T_RP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sd_cs,
  input  logic                    sd_ras,
  input  logic                    sd_cas,
  input  logic                    sd_we,
  input  logic [1:0]              sd_ba,
  input  logic [RAS_WIDTH-1:0]    sd_addr,
  input  logic [DATA_WIDTH/8-1:0] sd_dqm,
  input  logic [DATA_WIDTH-1:0]   sd_dq_i,
  output logic [DATA_WIDTH-1:0]   sd_dq_o,
  output logic                    sd_dq_oe,
  output logic                    mode_valid,
  output logic [1:0]              cas_lat,
  output logic [3:0]              bank_open,
  output logic [15:0]             refresh_cnt,
  output logic                    err,
  output logic [2:0]              err_code
);

  localparam int unsigned DQM_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  cmd_e                    cmd_c;
  logic [2:0]              code_c;
  logic                    err_c;
  logic [3:0]              open_d_c;
  logic                    act_early_c;
  logic                    rw_early_c;
  logic                    rd_fire_c;
  logic                    wr_fire_c;
  logic [MEM_AW-1:0]       mem_idx_c;

  logic [DATA_WIDTH-1:0]   mem [2**MEM_AW];
  logic [RAS_WIDTH-1:0]    row_q [4];

  logic                    s0_valid, s0_cl3, s1_valid;
  logic [DATA_WIDTH-1:0]   s0_data, s1_data;
  logic [DQM_W-1:0]        s0_dqm, s1_dqm;

  // Zero the byte lanes whose mask bit is set.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [DQM_W-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < int'(DQM_W); i++) begin
      if (m[i]) r[i*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  assign cmd_c     = sd_cs ? CMD_NOP : cmd_e'({sd_ras, sd_cas, sd_we});
  assign mem_idx_c = MEM_AW'({sd_ba, row_q[sd_ba], sd_addr[CAS_WIDTH-1:0]});

`ifdef SDRAM_RESP_TIMING_EN
  logic [2:0] tcnt [4];
  logic [3:0] restart_c;

  // Any bank whose open state flips this edge restarts its timing counter.
  assign restart_c   = bank_open ^ open_d_c;
  assign act_early_c = tcnt[sd_ba] < 3'(T_RP);
  assign rw_early_c  = tcnt[sd_ba] < 3'(T_RCD);

  // Per-bank clocks since last ACTIVE or close, saturating at 7.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (reset)             tcnt[b] <= 3'd7;
      else if (restart_c[b]) tcnt[b] <= 3'd1;
      else if (tcnt[b] != 3'd7) tcnt[b] <= tcnt[b] + 3'd1;
    end
  end
`else
  assign act_early_c = 1'b0;
  assign rw_early_c  = 1'b0;
`endif

  // Command legality check, then next bank-open state for accepted commands.
  always_comb begin
    code_c    = 3'd0;
    open_d_c  = bank_open;
    rd_fire_c = 1'b0;
    wr_fire_c = 1'b0;
    case (cmd_c)
      CMD_LMR: begin
        if (|bank_open) code_c = 3'd1;
        else if (!(sd_addr[6:4] == 3'd2 || sd_addr[6:4] == 3'd3) || sd_addr[2:0] != 3'd0)
          code_c = 3'd2;
      end
      CMD_REF: if (|bank_open) code_c = 3'd6;
      CMD_ACT: begin
        if (!mode_valid)           code_c = 3'd2;
        else if (bank_open[sd_ba]) code_c = 3'd3;
        else if (act_early_c)      code_c = 3'd5;
      end
      CMD_RD, CMD_WR: begin
        if (!mode_valid)            code_c = 3'd2;
        else if (!bank_open[sd_ba]) code_c = 3'd4;
        else if (rw_early_c)        code_c = 3'd5;
      end
      CMD_BST: code_c = 3'd7;
      default: code_c = 3'd0;
    endcase
    err_c = (code_c != 3'd0);
    if (!err_c && !reset) begin
      case (cmd_c)
        CMD_ACT: open_d_c[sd_ba] = 1'b1;
        CMD_PRE: begin
          if (sd_addr[10]) open_d_c = 4'd0;
          else             open_d_c[sd_ba] = 1'b0;
        end
        CMD_RD, CMD_WR: begin
          if (sd_addr[10]) open_d_c[sd_ba] = 1'b0;
          rd_fire_c = (cmd_c == CMD_RD);
          wr_fire_c = (cmd_c == CMD_WR);
        end
        default: ;
      endcase
    end
  end

  // Backing store, row latches and read-data stages (not reset).
  always_ff @(posedge clk) begin
    if (!reset && !err_c && cmd_c == CMD_ACT) row_q[sd_ba] <= sd_addr;
    if (wr_fire_c) begin
      for (int i = 0; i < int'(DQM_W); i++) begin
        if (!sd_dqm[i]) mem[mem_idx_c][i*8 +: 8] <= sd_dq_i[i*8 +: 8];
      end
    end
    if (rd_fire_c) begin
      s0_data <= mem[mem_idx_c];
      s0_dqm  <= sd_dqm;
    end
    s1_data <= s0_data;
    s1_dqm  <= s0_dqm;
  end

  // Control state, error capture and read-pipeline valid/output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_open   <= 4'd0;
      mode_valid  <= 1'b0;
      cas_lat     <= 2'd2;
      refresh_cnt <= 16'd0;
      err         <= 1'b0;
      err_code    <= 3'd0;
      s0_valid    <= 1'b0;
      s0_cl3      <= 1'b0;
      s1_valid    <= 1'b0;
      sd_dq_oe    <= 1'b0;
      sd_dq_o     <= '0;
    end else begin
      bank_open <= open_d_c;
      if (!err_c && cmd_c == CMD_LMR) begin
        cas_lat    <= sd_addr[5:4];
        mode_valid <= 1'b1;
      end
      if (!err_c && cmd_c == CMD_REF && refresh_cnt != 16'hFFFF)
        refresh_cnt <= refresh_cnt + 16'd1;
      if (err_c && !err) begin
        err      <= 1'b1;
        err_code <= code_c;
      end
      s0_valid <= rd_fire_c;
      s0_cl3   <= (cas_lat == 2'd3);
      s1_valid <= s0_valid && s0_cl3;
      if (s1_valid) begin
        sd_dq_oe <= 1'b1;
        sd_dq_o  <= lane_mask(s1_data, s1_dqm);
      end else if (s0_valid && !s0_cl3) begin
        sd_dq_oe <= 1'b1;
        sd_dq_o  <= lane_mask(s0_data, s0_dqm);
      end else begin
        sd_dq_oe <= 1'b0;
        sd_dq_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed-vector bench for sdram_responder: one command per clock, outputs
// compared against hand-computed expectations shortly after each rising edge.
module tb_sdram_responder;

  localparam logic [2:0] LMR = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011,
                         WR  = 3'b100, RD  = 3'b101, BST = 3'b110, NOP = 3'b111;
`ifdef SDRAM_RESP_TIMING_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sd_cs = 1'b1, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
  logic [1:0]  sd_ba = 2'd0;
  logic [12:0] sd_addr = 13'd0;
  logic [1:0]  sd_dqm = 2'd0;
  logic [15:0] sd_dq_i = 16'd0;
  logic [15:0] sd_dq_o;
  logic        sd_dq_oe, mode_valid, err;
  logic [1:0]  cas_lat;
  logic [3:0]  bank_open;
  logic [15:0] refresh_cnt;
  logic [2:0]  err_code;

  sdram_responder #(.DATA_WIDTH(16), .RAS_WIDTH(13), .CAS_WIDTH(9), .MEM_AW(16),
                    .T_RCD(2), .T_RP(1)) dut (
    .clk(clk), .reset(reset), .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas),
    .sd_we(sd_we), .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm),
    .sd_dq_i(sd_dq_i), .sd_dq_o(sd_dq_o), .sd_dq_oe(sd_dq_oe),
    .mode_valid(mode_valid), .cas_lat(cas_lat), .bank_open(bank_open),
    .refresh_cnt(refresh_cnt), .err(err), .err_code(err_code));

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, cs;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic        e_mv;
    logic [1:0]  e_cl;
    logic [3:0]  e_bo;
    logic        e_oe;
    logic [15:0] e_dq;
    logic        e_err;
    logic [2:0]  e_code;
    logic [15:0] e_rc;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(logic rst, logic cs, logic [2:0] cmd, logic [1:0] ba,
                              logic [12:0] addr, logic [1:0] dqm, logic [15:0] dq,
                              logic mv, logic [1:0] cl, logic [3:0] bo, logic oe,
                              logic [15:0] edq, logic er, logic [2:0] code,
                              logic [15:0] rc);
    vec_t v;
    v.rst = rst; v.cs = cs; v.cmd = cmd; v.ba = ba; v.addr = addr; v.dqm = dqm;
    v.dq = dq; v.e_mv = mv; v.e_cl = cl; v.e_bo = bo; v.e_oe = oe; v.e_dq = edq;
    v.e_err = er; v.e_code = code; v.e_rc = rc;
    return v;
  endfunction

  // Drive one command, let one rising edge pass, then compare all outputs.
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic ok;
    @(negedge clk);
    reset = v.rst; sd_cs = v.cs; {sd_ras, sd_cas, sd_we} = v.cmd;
    sd_ba = v.ba; sd_addr = v.addr; sd_dqm = v.dqm; sd_dq_i = v.dq;
    @(posedge clk);
    #1;
    ok = (mode_valid === v.e_mv) && (cas_lat === v.e_cl) && (bank_open === v.e_bo) &&
         (sd_dq_oe === v.e_oe) && (err === v.e_err) && (err_code === v.e_code) &&
         (refresh_cnt === v.e_rc);
    if (v.e_oe) ok = ok && (sd_dq_o === v.e_dq);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s[%0d]: got mv=%b cl=%0d bo=%b oe=%b dq=%h err=%b code=%0d rc=%0d ; want mv=%b cl=%0d bo=%b oe=%b dq=%h err=%b code=%0d rc=%0d",
               tag, idx, mode_valid, cas_lat, bank_open, sd_dq_oe, sd_dq_o, err, err_code,
               refresh_cnt, v.e_mv, v.e_cl, v.e_bo, v.e_oe, v.e_dq, v.e_err, v.e_code, v.e_rc);
    end
  endtask

  initial begin
    // Reset, mode load, write/read with auto-precharge, byte masks, CL change,
    // chip-select gating, refresh count, back-to-back reads at CL3.
    tbl.push_back(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,PRE,0,13'h400,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,LMR,0,13'h220,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,ACT,0,13'h005,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,WR ,0,13'h403,2'b00,16'hBEEF, 1,2,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,ACT,0,13'h005,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,RD ,0,13'h003,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,1,16'hBEEF,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,WR ,0,13'h003,2'b01,16'h1234, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,RD ,0,13'h003,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,RD ,0,13'h003,2'b01,16'h0000, 1,2,4'b0001,1,16'h12EF,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,1,16'h1200,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,PRE,0,13'h000,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,LMR,0,13'h230,2'b00,16'h0000, 1,3,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,ACT,0,13'h005,2'b00,16'h0000, 1,3,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0001,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,RD ,0,13'h403,2'b00,16'h0000, 1,3,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0000,1,16'h12EF,0,0,0));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,1,LMR,0,13'h220,2'b00,16'h0000, 1,3,4'b0000,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,REF,0,13'h000,2'b00,16'h0000, 1,3,4'b0000,0,16'h0000,0,0,1));
    tbl.push_back(mk(0,0,REF,0,13'h000,2'b00,16'h0000, 1,3,4'b0000,0,16'h0000,0,0,2));
    tbl.push_back(mk(0,0,ACT,0,13'h005,2'b00,16'h0000, 1,3,4'b0001,0,16'h0000,0,0,2));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0001,0,16'h0000,0,0,2));
    tbl.push_back(mk(0,0,RD ,0,13'h003,2'b00,16'h0000, 1,3,4'b0001,0,16'h0000,0,0,2));
    tbl.push_back(mk(0,0,RD ,0,13'h003,2'b10,16'h0000, 1,3,4'b0001,0,16'h0000,0,0,2));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0001,1,16'h12EF,0,0,2));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0001,1,16'h00EF,0,0,2));
    tbl.push_back(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,3,4'b0001,0,16'h0000,0,0,2));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table", i);

    // Reset one edge after a READ: no data may appear; then refresh with open bank.
    apply(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "rstrd", 0);
    apply(mk(0,0,LMR,0,13'h220,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,0,0,0), "rstrd", 1);
    apply(mk(0,0,ACT,0,13'h005,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0), "rstrd", 2);
    apply(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0), "rstrd", 3);
    apply(mk(0,0,RD ,0,13'h003,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0), "rstrd", 4);
    apply(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "rstrd", 5);
    apply(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "rstrd", 6);
    apply(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "rstrd", 7);
    apply(mk(0,0,LMR,0,13'h220,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,0,0,0), "refopen", 0);
    apply(mk(0,0,ACT,2,13'h001,2'b00,16'h0000, 1,2,4'b0100,0,16'h0000,0,0,0), "refopen", 1);
    apply(mk(0,0,REF,0,13'h000,2'b00,16'h0000, 1,2,4'b0100,0,16'h0000,1,6,0), "refopen", 2);
    apply(mk(0,0,BST,0,13'h000,2'b00,16'h0000, 1,2,4'b0100,0,16'h0000,1,6,0), "refopen", 3);

    // READ one clock after ACTIVE with tRCD=2: timing error only when checking is built in.
    apply(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "trcd", 0);
    apply(mk(0,0,LMR,0,13'h220,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,0,0,0), "trcd", 1);
    apply(mk(0,0,ACT,0,13'h005,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,0,0,0), "trcd", 2);
    apply(mk(0,0,RD ,0,13'h003,2'b00,16'h0000, 1,2,4'b0001,0,16'h0000,TEN,TEN ? 3'd5 : 3'd0,0), "trcd", 3);
    apply(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0001,!TEN,16'h12EF,TEN,TEN ? 3'd5 : 3'd0,0), "trcd", 4);

    // Access to a closed bank; later double ACTIVE must not overwrite the first code.
    apply(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "closed", 0);
    apply(mk(0,0,LMR,0,13'h220,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,0,0,0), "closed", 1);
    apply(mk(0,0,RD ,1,13'h000,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,1,4,0), "closed", 2);
    apply(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,1,4,0), "closed", 3);
    apply(mk(0,0,ACT,1,13'h000,2'b00,16'h0000, 1,2,4'b0010,0,16'h0000,1,4,0), "closed", 4);
    apply(mk(0,0,NOP,0,13'h000,2'b00,16'h0000, 1,2,4'b0010,0,16'h0000,1,4,0), "closed", 5);
    apply(mk(0,0,ACT,1,13'h000,2'b00,16'h0000, 1,2,4'b0010,0,16'h0000,1,4,0), "closed", 6);

    // Mode-register errors: ACTIVE before mode, bad CL, LOAD_MODE with open bank.
    apply(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "mode", 0);
    apply(mk(0,0,ACT,0,13'h005,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,1,2,0), "mode", 1);
    apply(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "mode", 2);
    apply(mk(0,0,LMR,0,13'h250,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,1,2,0), "mode", 3);
    apply(mk(1,0,NOP,0,13'h000,2'b00,16'h0000, 0,2,4'b0000,0,16'h0000,0,0,0), "mode", 4);
    apply(mk(0,0,LMR,0,13'h220,2'b00,16'h0000, 1,2,4'b0000,0,16'h0000,0,0,0), "mode", 5);
    apply(mk(0,0,ACT,3,13'h007,2'b00,16'h0000, 1,2,4'b1000,0,16'h0000,0,0,0), "mode", 6);
    apply(mk(0,0,LMR,0,13'h230,2'b00,16'h0000, 1,2,4'b1000,0,16'h0000,1,1,0), "mode", 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
